// File: rtl/branch_label_encoder_if.sv
// Request/response bundle between the assembler front-end, the label encoder
// and instruction memory.
interface branch_label_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs;
  logic [31:0] in_offset;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_mode, in_opcode, in_rs, in_offset, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_opcode, in_rs, in_offset, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/branch_label_encoder.sv
// Range-checks a signed branch offset and packs it into a miniRISC J-type
// (26-bit label) or conditional-branch (rs + 16-bit label) instruction word.
module branch_label_encoder #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  branch_label_encoder_if.slave bus,
  output logic [CNT_W-1:0]   err_count,
  output logic [15:0]        instr_count
);

  typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

  state_t      state_reg, state_next;
  logic        mode_reg;
  logic [5:0]  opcode_reg;
  logic [4:0]  rs_reg;
  logic [31:0] offset_reg;
  logic [31:0] instr_reg;
  logic        err_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic [15:0] instr_cnt_reg;

  logic ready_c, valid_c, capture_c, encode_c, deliver_c;
  logic long_fits, short_fits, fits;
  logic [31:0] packed_instr;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    valid_c    = 1'b0;
    capture_c  = 1'b0;
    encode_c   = 1'b0;
    deliver_c  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          capture_c  = 1'b1;
          state_next = ENCODE;
        end
      end
      ENCODE: begin
        encode_c   = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        valid_c = 1'b1;
        if (bus.out_ready) begin
          deliver_c  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A label fits when every bit above its sign bit replicates the sign bit,
  // which is exactly what the core's sign-extension will reconstruct.
  assign long_fits  = (&offset_reg[31:25]) | ~(|offset_reg[31:25]);
  assign short_fits = (&offset_reg[31:15]) | ~(|offset_reg[31:15]);
  assign fits       = mode_reg ? short_fits : long_fits;

  always_comb begin
    packed_instr = 32'h0000_0000;
    if (fits) begin
      if (mode_reg) packed_instr = {opcode_reg, rs_reg, 5'b00000, offset_reg[15:0]};
      else          packed_instr = {opcode_reg, offset_reg[25:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg   <= 1'b0;
      opcode_reg <= '0;
      rs_reg     <= '0;
      offset_reg <= '0;
    end else if (capture_c) begin
      mode_reg   <= bus.in_mode;
      opcode_reg <= bus.in_opcode;
      rs_reg     <= bus.in_rs;
      offset_reg <= bus.in_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg     <= '0;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (encode_c) begin
        instr_reg <= packed_instr;
        err_reg   <= ~fits;
        if (!fits && err_cnt_reg != {CNT_W{1'b1}})
          err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
      // Errored NOPs are still delivered, so they count as instructions.
      if (deliver_c)
        instr_cnt_reg <= instr_cnt_reg + 16'd1;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = valid_c;
  assign bus.out_instr = instr_reg;
  assign bus.out_err   = err_reg;
  assign err_count     = err_cnt_reg;
  assign instr_count   = instr_cnt_reg;

endmodule

// File: tb/tb_branch_label_encoder.sv
// Scoreboard bench for branch_label_encoder: directed vectors push expected
// words, a negedge monitor pops and compares at every output handshake.
module tb_branch_label_encoder;

  logic        clk;
  logic        rst;
  logic [7:0]  err_count;
  logic [15:0] instr_count;

  branch_label_encoder_if bus ();

  branch_label_encoder #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_count   (err_count),
    .instr_count (instr_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        mode;
    logic [31:0] off;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_err = 8'd0;
  logic [15:0] model_instr = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every delivered word against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] sx;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got instr %h err %b, expected no output", bus.out_instr, bus.out_err);
      end else begin
        e = q.pop_front();
        chk("out_instr", bus.out_instr, e.instr);
        chk("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
        if (!e.err) begin
          sx = e.mode ? {{16{bus.out_instr[15]}}, bus.out_instr[15:0]}
                      : {{6{bus.out_instr[25]}}, bus.out_instr[25:0]};
          chk("label_roundtrip", sx, e.off);
        end
        $display("txn mode=%0d off=%h instr=%h err=%0d", e.mode, e.off, bus.out_instr, bus.out_err);
      end
      model_instr = model_instr + 16'd1;
    end
  end

  task automatic send(input logic mode, input logic [5:0] op, input logic [4:0] rs,
                      input logic [31:0] off, input logic [31:0] ei, input logic ee);
    int n = 0;
    exp_t e;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 after 100 cycles, expected 1");
    end
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_opcode = op;
    bus.in_rs     = rs;
    bus.in_offset = off;
    e.instr = ei; e.err = ee; e.mode = mode; e.off = off;
    q.push_back(e);
    if (ee && model_err != 8'hFF) model_err = model_err + 8'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_err_count"}, {24'd0, err_count}, {24'd0, model_err});
    chk({tag, "_instr_count"}, {16'd0, instr_count}, {16'd0, model_instr});
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_opcode = '0;
    bus.in_rs     = '0;
    bus.in_offset = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out_instr", bus.out_instr, 32'h0);
    chk_counters("reset");

    // First vector also checks the ENCODE bubble and HOLD timing.
    send(1'b0, 6'h02, 5'd0, 32'h0000_1234, 32'h0800_1234, 1'b0);
    chk("encode_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("encode_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    drain();

    send(1'b1, 6'h04, 5'd3,  32'hFFFF_8000, 32'h1060_8000, 1'b0);
    send(1'b1, 6'h04, 5'd0,  32'h0000_8000, 32'h0000_0000, 1'b1);
    send(1'b0, 6'h02, 5'd0,  32'h01FF_FFFF, 32'h09FF_FFFF, 1'b0);
    send(1'b0, 6'h02, 5'd0,  32'h0200_0000, 32'h0000_0000, 1'b1);
    send(1'b1, 6'h05, 5'd31, 32'h0000_7FFF, 32'h17E0_7FFF, 1'b0);
    send(1'b1, 6'h04, 5'd0,  32'hFFFF_7FFF, 32'h0000_0000, 1'b1);
    send(1'b0, 6'h03, 5'd0,  32'hFE00_0000, 32'h0E00_0000, 1'b0);
    send(1'b0, 6'h03, 5'd0,  32'hFDFF_FFFF, 32'h0000_0000, 1'b1);
    send(1'b0, 6'h02, 5'd7,  32'hFFFF_FFFF, 32'h0BFF_FFFF, 1'b0);
    drain();
    chk_counters("vectors");

    // Back-pressure: output held, a competing request must be ignored.
    bus.out_ready = 1'b0;
    send(1'b0, 6'h02, 5'd0, 32'h0000_0010, 32'h0800_0010, 1'b0);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 1'b1;
    bus.in_opcode = 6'h3F;
    bus.in_offset = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_instr", bus.out_instr, 32'h0800_0010);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_extra", {31'd0, bus.out_valid}, 32'd0);
    chk_counters("backpressure");

    // Reset for two cycles while an errored word sits in HOLD.
    bus.out_ready = 1'b0;
    send(1'b1, 6'h04, 5'd0, 32'h0001_0000, 32'h0000_0000, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    model_err     = 8'd0;
    model_instr   = 16'd0;
    bus.out_ready = 1'b1;
    chk("rst_hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_hold_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_hold_out_err", {31'd0, bus.out_err}, 32'd0);
    chk_counters("rst_hold");

    // Saturate the error counter.
    for (int i = 0; i < 300; i++)
      send(1'b0, 6'h01, 5'd0, 32'h4000_0000, 32'h0000_0000, 1'b1);
    drain();
    chk("sat_err_count", {24'd0, err_count}, 32'h0000_00FF);
    chk_counters("saturate");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
